des_round_engine: RTL and testbench
===================================

Name: des_round_engine

Overview:
Iterative DES Feistel engine that sits directly upstream and downstream of des_scomp.
- Applies IP to an input block.
- Each round, drives E(R) xor subkey to the S-box stage and consumes its 32-bit result.
- Applies the P permutation, performs the Feistel XOR/swap, and applies FP after the last round.
- Subkeys come from an external key schedule, indexed by round_idx_out, so one engine serves encrypt and decrypt.

Parameters:
ROUNDS, 16, number of Feistel rounds executed (legal 1..16; below 16 for debug only).

Ports:
clk_in  input  1  clock
rst_n_in  input  1  asynchronous active-low reset
data_in  input  64  plaintext/ciphertext block, FIPS 46-3 bit 1 = data_in[63]
data_in_valid  input  1  block offered
data_in_ready  output  1  engine idle, can accept
subkey_in  input  48  subkey for round_idx_out, FIPS bit 1 = subkey_in[47]
round_idx_out  output  4  current round 0..ROUNDS-1
s_data_out  output  48  expanded R xor subkey, in S-box group packing
s_data_out_valid  output  1  one-cycle request to des_scomp
scomp_in  input  32  S-box result from des_scomp
scomp_in_valid  input  1  S-box result valid
data_out  output  64  result block, FIPS bit 1 = data_out[63]
data_out_valid  output  1  one-cycle result strobe
busy  output  1  high in any state other than IDLE
protocol_err  output  1  sticky: scomp_in_valid seen outside WAIT

Behaviour:
- Clocking and reset are decided: one clock, clk_in; reset rst_n_in is asynchronous and active-low.
- Reset values:
  - All registers 0; state IDLE.
  - data_in_ready=1.
  - data_out, data_out_valid, s_data_out_valid, busy, protocol_err, round_idx_out all 0.
- Tables: standard FIPS 46-3 IP, FP (IP^-1), E and P, in FIPS MSB-first order.
- Packing into s_data_out:
  - X = E(R) xor subkey_in, computed in FIPS order.
  - FIPS bit i (1..48) goes to s_data_out[6k-1-p], where k=ceil(i/6) and p=(i-1) mod 6.
  - So S-box 1 occupies [5:0], and its first bit sits at [5].
- Unpacking scomp_in: the FIPS S-output bit j (1..32) feeding P is scomp_in[4k-1-p], where k=ceil(j/4) and p=(j-1) mod 4.
- State IDLE:
  - data_in_ready=1.
  - On data_in_valid: {L,R} <= IP(data_in), round <= 0, protocol_err <= 0, go to ISSUE.
- State ISSUE (exactly one cycle):
  - s_data_out_valid=1; s_data_out is combinational from R and subkey_in.
  - round_idx_out=round, stable for all of ISSUE and WAIT.
  - Go to WAIT.
- State WAIT:
  - s_data_out_valid=0; stay until scomp_in_valid (any number of cycles).
  - On scomp_in_valid with round<ROUNDS-1: L <= R, R <= L xor P(scomp_in), round++, go to ISSUE.
  - On scomp_in_valid with round==ROUNDS-1 (no swap):
    - data_out <= FP({L xor P(scomp_in), R}).
    - data_out_valid <= 1 for one cycle.
    - Go to IDLE.
- Latency with des_scomp (1-cycle) attached:
  - Each round takes 2 cycles.
  - data_out_valid rises 2*ROUNDS cycles after the accepting edge (32 for ROUNDS=16).
- data_out holds its value until the next completion.
- data_in_valid is ignored while busy; data_in_ready=0 outside IDLE.
- New acceptance is allowed in the same cycle data_out_valid is high (IDLE reached), giving back-to-back throughput of one block per 2*ROUNDS+1 cycles.
- scomp_in_valid in IDLE or ISSUE: ignored for datapath purposes; sets protocol_err, which stays set until the next acceptance.
- Reset mid-operation: immediate return to the reset values. No data_out_valid is produced for the aborted block.

Test Plan:
- Known vector: key 133457799BBCDFF1 (bench key schedule; K1=1B02EFFC7072), data_in 0123456789ABCDEF, real des_scomp attached -> data_out 85E813540F0AB405, data_out_valid exactly 32 cycles after accept, round_idx_out steps 0..15.
- Zero vector: key 0000000000000000, data 0000000000000000 -> 8CA64DE9C1B123A7.
- Decrypt via reversed subkey order: key 133457799BBCDFF1, data_in 85E813540F0AB405 -> data_out 0123456789ABCDEF.
- Stalled S-box: bench model returns scomp_in_valid 3 cycles after each request -> same ciphertext as the known vector; latency 16*(1+3)=64 cycles; s_data_out_valid pulses exactly 16 times.
- Back-to-back and busy rejection:
  - Hold data_in_valid high with two blocks queued; second is accepted only on the cycle data_out_valid=1.
  - A third offer made mid-operation is not consumed.
- Errors and reset:
  - Spurious scomp_in_valid in IDLE -> protocol_err=1, cleared by the next accept.
  - Assert rst_n_in during round 7 -> busy=0, data_in_ready=1, no data_out_valid.
  - A following known-vector run then passes.

Source files
------------

// File: rtl/des_round_engine.sv
// Iterative DES Feistel round engine: IP in, one S-box request per round, FP out.
// Key schedule and S-boxes live outside; subkeys are fetched by round_idx_out.
//   state   | meaning
//   IDLE    | ready for a block, result held on data_out
//   ISSUE   | one-cycle request of E(R)^K to the S-box stage
//   WAIT    | waiting (any length) for the S-box result
module des_round_engine #(
  parameter int ROUNDS = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [63:0] data_in,
  input  logic        data_in_valid,
  output logic        data_in_ready,
  input  logic [47:0] subkey_in,
  output logic [3:0]  round_idx_out,
  output logic [47:0] s_data_out,
  output logic        s_data_out_valid,
  input  logic [31:0] scomp_in,
  input  logic        scomp_in_valid,
  output logic [63:0] data_out,
  output logic        data_out_valid,
  output logic        busy,
  output logic        protocol_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  // Tables are FIPS 1-based, MSB-first: FIPS bit n of a W-bit vector is [W-n].
  function automatic logic [63:0] perm64(input logic [63:0] x, input logic fp);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 64; n++)
      y[6'(63 - n)] = x[6'(64 - (fp ? FP_T[n] : IP_T[n]))];
    return y;
  endfunction

  function automatic logic [47:0] expand(input logic [31:0] r);
    logic [47:0] y;
    y = '0;
    for (int n = 0; n < 48; n++) y[6'(47 - n)] = r[5'(32 - E_T[n])];
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int n = 0; n < 32; n++) y[5'(31 - n)] = x[5'(32 - P_T[n])];
    return y;
  endfunction

  // S-box groups are swapped end-for-end: group 1 sits in the low bits.
  function automatic logic [47:0] pack_s(input logic [47:0] x);
    logic [47:0] y;
    y = '0;
    for (int g = 0; g < 8; g++) y[6'(6 * g) +: 6] = x[6'(42 - 6 * g) +: 6];
    return y;
  endfunction

  function automatic logic [31:0] unpack_s(input logic [31:0] c);
    logic [31:0] y;
    y = '0;
    for (int g = 0; g < 8; g++) y[5'(28 - 4 * g) +: 4] = c[5'(4 * g) +: 4];
    return y;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [3:0]  round_q, round_d;
  logic [63:0] dout_q, dout_d;
  logic        dov_q, dov_d;
  logic        perr_q, perr_d;
  logic [31:0] f_out;
  logic [63:0] ip_blk;

  assign s_data_out = pack_s(expand(r_q) ^ subkey_in);
  assign f_out      = perm_p(unpack_s(scomp_in));
  assign ip_blk     = perm64(data_in, 1'b0);

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    round_d = round_q;
    dout_d  = dout_q;
    dov_d   = 1'b0;
    perr_d  = perr_q;
    case (state_q)
      S_IDLE: begin
        if (data_in_valid) begin
          l_d     = ip_blk[63:32];
          r_d     = ip_blk[31:0];
          round_d = 4'd0;
          perr_d  = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (scomp_in_valid) begin
          if (round_q == LAST_ROUND) begin
            // Final round skips the swap.
            dout_d  = perm64({l_q ^ f_out, r_q}, 1'b1);
            dov_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            l_d     = r_q;
            r_d     = l_q ^ f_out;
            round_d = round_q + 4'd1;
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (scomp_in_valid && (state_q != S_WAIT)) perr_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      l_q     <= '0;
      r_q     <= '0;
      round_q <= '0;
      dout_q  <= '0;
      dov_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      round_q <= round_d;
      dout_q  <= dout_d;
      dov_q   <= dov_d;
      perr_q  <= perr_d;
    end
  end

  assign data_in_ready    = (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);
  assign s_data_out_valid = (state_q == S_ISSUE);
  assign round_idx_out    = round_q;
  assign data_out         = dout_q;
  assign data_out_valid   = dov_q;
  assign protocol_err     = perr_q;

endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine with a DES key schedule and an S-box stage model
// whose response delay is adjustable.
module tb_des_round_engine;
  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [63:0] data_in = '0;
  logic        data_in_valid = 1'b0;
  logic        data_in_ready;
  logic [47:0] subkey_in;
  logic [3:0]  round_idx_out;
  logic [47:0] s_data_out;
  logic        s_data_out_valid;
  logic [31:0] scomp_in;
  logic        scomp_in_valid;
  logic [63:0] data_out;
  logic        data_out_valid;
  logic        busy;
  logic        protocol_err;

  int tests = 0;
  int fails = 0;
  logic [47:0] ks [16];
  bit          dec = 1'b0;
  int          delay = 1;
  logic        spur_v = 1'b0;
  logic        mdl_valid;
  int          pend_cnt;
  logic [47:0] pend_data;

  localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT_STD  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT_STD  = 64'h85E813540F0AB405;
  localparam logic [63:0] CT_ZERO = 64'h8CA64DE9C1B123A7;

  des_round_engine #(.ROUNDS(16)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .subkey_in(subkey_in), .round_idx_out(round_idx_out),
    .s_data_out(s_data_out), .s_data_out_valid(s_data_out_valid),
    .scomp_in(scomp_in), .scomp_in_valid(scomp_in_valid),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .busy(busy), .protocol_err(protocol_err));

  always #5 clk_in = ~clk_in;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int SB [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // Group g of the packed request is S-box g+1, six bits MSB-first.
  function automatic logic [31:0] sbox_all(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  b;
    y = '0;
    for (int g = 0; g < 8; g++) begin
      b = x[6 * g +: 6];
      y[4 * g +: 4] = 4'(SB[g * 64 + int'({b[5], b[0]}) * 16 + int'(b[4:1])]);
    end
    return y;
  endfunction

  task automatic set_key(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    for (int n = 0; n < 56; n++) cd[55 - n] = key[64 - PC1[n]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int n = 0; n < 48; n++) ks[r][47 - n] = cd[56 - PC2[n]];
    end
  endtask

  always_comb subkey_in = dec ? ks[4'd15 - round_idx_out] : ks[round_idx_out];

  assign scomp_in_valid = mdl_valid | spur_v;

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mdl_valid <= 1'b0;
      pend_cnt  <= 0;
      pend_data <= '0;
      scomp_in  <= '0;
    end else begin
      mdl_valid <= 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt <= pend_cnt - 1;
        if (pend_cnt == 1) begin
          mdl_valid <= 1'b1;
          scomp_in  <= sbox_all(pend_data);
        end
      end
      if (s_data_out_valid) begin
        if (delay == 1) begin
          mdl_valid <= 1'b1;
          scomp_in  <= sbox_all(s_data_out);
        end else begin
          pend_cnt  <= delay - 1;
          pend_data <= s_data_out;
        end
      end
    end
  end

  // Offer one block and follow it to completion; k counts edges after acceptance.
  task automatic do_block(input logic [63:0] blk, input int spur_k,
                          output logic [63:0] res, output int lat, output int npulse,
                          output int round_err, output logic perr0, output logic perr_end);
    @(negedge clk_in);
    data_in = blk;
    data_in_valid = 1'b1;
    @(negedge clk_in);
    data_in_valid = 1'b0;
    lat = -1; npulse = 0; round_err = 0; perr0 = 1'bx;
    for (int k = 0; k < 200; k++) begin
      if (k == 0) perr0 = protocol_err;
      if (k == spur_k) spur_v = 1'b1;
      if (s_data_out_valid) begin
        if (round_idx_out != 4'(npulse)) round_err++;
        npulse++;
      end
      if (data_out_valid) begin
        lat = k;
        break;
      end
      @(negedge clk_in);
      spur_v = 1'b0;
    end
    spur_v = 1'b0;
    res = data_out;
    perr_end = protocol_err;
  endtask

  logic [63:0] res;
  int lat, npulse, rerr;
  logic perr0, perr_end;

  task automatic test_reset();
    #1;
    tests++; if (data_in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", data_in_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (data_out_valid !== 1'b0) begin fails++; $display("FAIL reset_dov: got %b expected 0", data_out_valid); end
    tests++; if (s_data_out_valid !== 1'b0) begin fails++; $display("FAIL reset_sdv: got %b expected 0", s_data_out_valid); end
    tests++; if (protocol_err !== 1'b0) begin fails++; $display("FAIL reset_perr: got %b expected 0", protocol_err); end
    tests++; if (round_idx_out !== 4'd0) begin fails++; $display("FAIL reset_round: got %0d expected 0", round_idx_out); end
    tests++; if (data_out !== 64'h0) begin fails++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  task automatic test_known(input string tag);
    set_key(KEY_STD); dec = 1'b0; delay = 1;
    do_block(PT_STD, -1, res, lat, npulse, rerr, perr0, perr_end);
    tests++; if (res !== CT_STD) begin fails++; $display("FAIL %s_ct: got %h expected %h", tag, res, CT_STD); end
    tests++; if (lat !== 32) begin fails++; $display("FAIL %s_latency: got %0d expected 32", tag, lat); end
    tests++; if (npulse !== 16 || rerr !== 0) begin fails++; $display("FAIL %s_rounds: got %0d pulses %0d bad idx expected 16 and 0", tag, npulse, rerr); end
    @(negedge clk_in);
    tests++; if (data_out_valid !== 1'b0) begin fails++; $display("FAIL %s_dov_pulse: got %b expected 0", tag, data_out_valid); end
    tests++; if (data_out !== CT_STD) begin fails++; $display("FAIL %s_hold: got %h expected %h", tag, data_out, CT_STD); end
  endtask

  task automatic test_zero();
    set_key(64'h0); dec = 1'b0; delay = 1;
    do_block(64'h0, -1, res, lat, npulse, rerr, perr0, perr_end);
    tests++; if (res !== CT_ZERO) begin fails++; $display("FAIL zero_ct: got %h expected %h", res, CT_ZERO); end
    tests++; if (lat !== 32) begin fails++; $display("FAIL zero_latency: got %0d expected 32", lat); end
  endtask

  task automatic test_decrypt();
    set_key(KEY_STD); dec = 1'b1; delay = 1;
    do_block(CT_STD, -1, res, lat, npulse, rerr, perr0, perr_end);
    tests++; if (res !== PT_STD) begin fails++; $display("FAIL decrypt_pt: got %h expected %h", res, PT_STD); end
    dec = 1'b0;
  endtask

  task automatic test_stall();
    set_key(KEY_STD); dec = 1'b0; delay = 3;
    do_block(PT_STD, -1, res, lat, npulse, rerr, perr0, perr_end);
    tests++; if (res !== CT_STD) begin fails++; $display("FAIL stall_ct: got %h expected %h", res, CT_STD); end
    tests++; if (lat !== 64) begin fails++; $display("FAIL stall_latency: got %0d expected 64", lat); end
    tests++; if (npulse !== 16) begin fails++; $display("FAIL stall_pulses: got %0d expected 16", npulse); end
    delay = 1;
  endtask

  task automatic test_back_to_back();
    int bad_ready;
    bad_ready = 0;
    set_key(KEY_STD); dec = 1'b0; delay = 1;
    @(negedge clk_in);
    data_in = PT_STD; data_in_valid = 1'b1;
    @(negedge clk_in);
    data_in = CT_STD;  // second block waits with valid held high
    for (int k = 0; k <= 66; k++) begin
      if (k < 32 && data_in_ready !== 1'b0) bad_ready++;
      if (k == 32) begin
        tests++; if (data_out_valid !== 1'b1 || data_in_ready !== 1'b1) begin fails++; $display("FAIL b2b_first_done: got dov=%b ready=%b expected 1 1", data_out_valid, data_in_ready); end
        tests++; if (data_out !== CT_STD) begin fails++; $display("FAIL b2b_first_ct: got %h expected %h", data_out, CT_STD); end
        dec = 1'b1;
      end
      if (k == 33) begin
        tests++; if (busy !== 1'b1 || s_data_out_valid !== 1'b1 || round_idx_out !== 4'd0) begin fails++; $display("FAIL b2b_second_accept: got busy=%b sdv=%b round=%0d expected 1 1 0", busy, s_data_out_valid, round_idx_out); end
      end
      if (k == 40) data_in = 64'h0;
      if (k == 50) data_in_valid = 1'b0;
      if (k == 65) begin
        tests++; if (data_out_valid !== 1'b1 || data_out !== PT_STD) begin fails++; $display("FAIL b2b_second_pt: got dov=%b data=%h expected 1 %h", data_out_valid, data_out, PT_STD); end
      end
      if (k == 66) begin
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_third_consumed: got busy=%b expected 0", busy); end
      end
      @(negedge clk_in);
    end
    tests++; if (bad_ready !== 0) begin fails++; $display("FAIL b2b_ready_busy: got %0d ready cycles expected 0", bad_ready); end
    dec = 1'b0;
  endtask

  task automatic test_protocol_err();
    set_key(KEY_STD); dec = 1'b0; delay = 1;
    @(negedge clk_in); spur_v = 1'b1;
    @(negedge clk_in); spur_v = 1'b0;
    tests++; if (protocol_err !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL perr_idle: got perr=%b busy=%b expected 1 0", protocol_err, busy); end
    do_block(PT_STD, 0, res, lat, npulse, rerr, perr0, perr_end);
    tests++; if (perr0 !== 1'b0) begin fails++; $display("FAIL perr_cleared: got %b expected 0", perr0); end
    tests++; if (perr_end !== 1'b1) begin fails++; $display("FAIL perr_issue_sticky: got %b expected 1", perr_end); end
    tests++; if (res !== CT_STD || lat !== 32) begin fails++; $display("FAIL perr_issue_ct: got %h lat %0d expected %h lat 32", res, lat, CT_STD); end
  endtask

  task automatic test_reset_mid();
    bit found;
    int ndov;
    found = 1'b0; ndov = 0;
    set_key(KEY_STD); dec = 1'b0; delay = 1;
    @(negedge clk_in);
    data_in = PT_STD; data_in_valid = 1'b1;
    @(negedge clk_in);
    data_in_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (s_data_out_valid && round_idx_out == 4'd7) begin
        found = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    tests++; if (found !== 1'b1) begin fails++; $display("FAIL rst_mid_round7: got %b expected 1", found); end
    rst_n_in = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || data_in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_state: got busy=%b ready=%b expected 0 1", busy, data_in_ready); end
    tests++; if (round_idx_out !== 4'd0 || data_out !== 64'h0) begin fails++; $display("FAIL rst_mid_regs: got round=%0d data=%h expected 0 0", round_idx_out, data_out); end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (data_out_valid) ndov++;
      @(negedge clk_in);
    end
    tests++; if (ndov !== 0 || busy !== 1'b0) begin fails++; $display("FAIL rst_mid_no_dov: got %0d strobes busy=%b expected 0 0", ndov, busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_known("known");
    test_zero();
    test_decrypt();
    test_stall();
    test_back_to_back();
    test_protocol_err();
    test_reset_mid();
    test_known("after_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
